// File: rtl/psw_datapath.sv
// psw_datapath: keypad digit capture with debounce, password/challenge shift registers and match status.
module psw_datapath #(
  parameter int DIGIT_W = 4,
  parameter int MAX_DIGITS = 8,
  parameter int DEBOUNCE = 2,
  parameter int MASTER_LEN = 8,
  parameter logic [MASTER_LEN*DIGIT_W-1:0] MASTER_PSW = 32'h1234_5678,
  localparam int LEN_W = $clog2(MAX_DIGITS+1)
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic [9:0]         key_i,
  input  logic               mem_rst_i,
  input  logic               mem_sl_i,
  input  logic               buff_rst_i,
  input  logic               buff_sl_i,
  output logic               input_valid_o,
  output logic [DIGIT_W-1:0] digit_o,
  output logic               same_o,
  output logic               master_same_o,
  output logic               mem_limit_o,
  output logic               buff_limit_o,
  output logic [LEN_W-1:0]   mem_len_o,
  output logic [LEN_W-1:0]   buff_len_o
);
  localparam int W = MAX_DIGITS*DIGIT_W;
  localparam int CNT_W = $clog2(DEBOUNCE+1);
  typedef enum logic [1:0] {IDLE, PRESSED, INVALID} state_t;
  state_t r_state, w_next;
  logic [CNT_W-1:0] r_cnt;
  logic [9:0] r_key;
  logic [DIGIT_W-1:0] r_idx, r_digit, w_idx;
  logic r_valid, w_capture, w_hold, w_accept;
  logic [W-1:0] r_mem, r_buff;
  logic [LEN_W-1:0] r_mem_len, r_buff_len;
  always_comb begin
    w_idx = '0;
    for (int n = 0; n < 10; n++) if (key_i[n]) w_idx = DIGIT_W'(n);
  end
  always_comb begin
    w_next = r_state;
    w_capture = 1'b0;
    w_hold = 1'b0;
    w_accept = 1'b0;
    case (r_state)
      IDLE: begin
        w_capture = $onehot(key_i);
        w_next = w_capture ? PRESSED : (|key_i ? INVALID : IDLE);
      end
      PRESSED: begin
        w_hold = (key_i == r_key) && (r_cnt < CNT_W'(DEBOUNCE));
        w_accept = (key_i == '0) && (r_cnt >= CNT_W'(DEBOUNCE));
        w_next = (key_i == r_key) ? PRESSED : ((key_i == '0) ? IDLE : INVALID);
      end
      INVALID: w_next = (key_i == '0) ? IDLE : INVALID;
      default: w_next = IDLE;
    endcase
  end
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_state <= IDLE;
      r_cnt <= '0;
      r_key <= '0;
      r_idx <= '0;
      r_digit <= '0;
      r_valid <= 1'b0;
    end else begin
      r_state <= w_next;
      r_valid <= w_accept;
      if (w_accept) r_digit <= r_idx;
      if (w_capture) begin
        r_key <= key_i;
        r_idx <= w_idx;
        r_cnt <= CNT_W'(1);
      end else if (w_hold) r_cnt <= r_cnt + 1'b1;
    end
  end
  // Full registers ignore further shifts; reset and clear strobes take priority.
  always_ff @(posedge clk_i) begin
    if (reset_i || mem_rst_i) begin
      r_mem <= '0;
      r_mem_len <= '0;
    end else if (mem_sl_i && !mem_limit_o) begin
      r_mem <= {r_mem[W-DIGIT_W-1:0], r_digit};
      r_mem_len <= r_mem_len + 1'b1;
    end
    if (reset_i || buff_rst_i) begin
      r_buff <= '0;
      r_buff_len <= '0;
    end else if (buff_sl_i && !buff_limit_o) begin
      r_buff <= {r_buff[W-DIGIT_W-1:0], r_digit};
      r_buff_len <= r_buff_len + 1'b1;
    end
  end
  assign input_valid_o = r_valid;
  assign digit_o = r_digit;
  assign mem_len_o = r_mem_len;
  assign buff_len_o = r_buff_len;
  assign mem_limit_o = r_mem_len == LEN_W'(MAX_DIGITS);
  assign buff_limit_o = r_buff_len == LEN_W'(MAX_DIGITS);
  assign same_o = (r_mem_len == r_buff_len) && (r_mem_len != '0) && (r_mem == r_buff);
  assign master_same_o = (r_buff_len == LEN_W'(MASTER_LEN)) && (r_buff[MASTER_LEN*DIGIT_W-1:0] == MASTER_PSW);
endmodule
